// File: rtl/tri_array_2r1w_init.sv
// -----------------------------------------------------------------------------
// tri_array_2r1w_init
// DEPTH x WIDTH register-file array with one write port and two independent,
// registered read ports (1-cycle latency).
//
// After every synchronous reset, a clear sequencer writes INIT_VAL into every
// entry, one entry per cycle. While the sequencer is running, all accesses are
// ignored.
//
// Ports
//   clk        array clock; all state changes on the rising edge
//   sreset     synchronous active-high reset
//   wr_act     write enable
//   wr_adr     write address
//   di         write data
//   rd0_act    read port 0 enable
//   rd0_adr    read port 0 address
//   do0        read port 0 data (registered)
//   rd1_act    read port 1 enable
//   rd1_adr    read port 1 address
//   do1        read port 1 data (registered)
//   init_busy  high while in reset or while the clear sequence is running
//   init_done  single-cycle pulse on the first cycle after the clear completes
// -----------------------------------------------------------------------------
module tri_array_2r1w_init #(
  parameter int               DEPTH    = 64,
  parameter int               ADDR_W   = 6,
  parameter int               WIDTH    = 72,
  parameter bit               BYPASS   = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              sreset,
  input  logic              wr_act,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [WIDTH-1:0]  di,
  input  logic              rd0_act,
  input  logic [ADDR_W-1:0] rd0_adr,
  output logic [WIDTH-1:0]  do0,
  input  logic              rd1_act,
  input  logic [ADDR_W-1:0] rd1_adr,
  output logic [WIDTH-1:0]  do1,
  output logic              init_busy,
  output logic              init_done
);

  typedef enum logic [1:0] {ST_RST, ST_CLEAR, ST_READY} state_t;

  // One extra bit so that DEPTH == 2**ADDR_W does not wrap to zero.
  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_next;
  logic              r_init_done, w_init_done_next;

  // Single physical write port, shared by the clear sequencer and the user.
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_adr;
  logic [WIDTH-1:0]  w_mem_dat;
  logic              w_wr_in_range;

  logic [WIDTH-1:0]  r_mem [DEPTH];

  assign w_wr_in_range = ({1'b0, wr_adr} < LP_DEPTH);

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state     <= ST_RST;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clr_cnt   <= w_clr_cnt_next;
      r_init_done <= w_init_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_clr_cnt_next   = r_clr_cnt;
    w_init_done_next = 1'b0;
    w_mem_we         = 1'b0;
    w_mem_adr        = wr_adr;
    w_mem_dat        = di;
    case (r_state)
      ST_RST: begin
        w_state_next   = ST_CLEAR;
        w_clr_cnt_next = '0;
      end
      ST_CLEAR: begin
        w_mem_we  = !sreset;
        w_mem_adr = r_clr_cnt;
        w_mem_dat = INIT_VAL;
        if (r_clr_cnt == LP_LAST) begin
          w_state_next     = ST_READY;
          w_clr_cnt_next   = '0;
          w_init_done_next = 1'b1;
        end else begin
          w_clr_cnt_next = r_clr_cnt + 1'b1;
        end
      end
      ST_READY: begin
        // Out-of-range writes are silently dropped.
        w_mem_we = wr_act && w_wr_in_range && !sreset;
      end
      default: begin
        w_state_next = ST_RST;
      end
    endcase
  end

  // Array storage is never reset; the clear sequencer provides the contents.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_adr] <= w_mem_dat;
    end
  end

  logic [1:0]        w_rd_act;
  logic [ADDR_W-1:0] w_rd_adr [2];
  logic [WIDTH-1:0]  w_do     [2];

  assign w_rd_act    = {rd1_act, rd0_act};
  assign w_rd_adr[0] = rd0_adr;
  assign w_rd_adr[1] = rd1_adr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic             w_in_range;
      logic             w_hit;
      logic [WIDTH-1:0] r_do;

      assign w_in_range = ({1'b0, w_rd_adr[gi]} < LP_DEPTH);
      // Forwarding only applies to an in-range write that actually happens.
      assign w_hit      = BYPASS && wr_act && (wr_adr == w_rd_adr[gi]);

      // Without forwarding, the nonblocking array read naturally returns the
      // pre-write contents on a same-edge collision.
      always_ff @(posedge clk) begin
        if (sreset) begin
          r_do <= '0;
        end else if (r_state != ST_READY) begin
          r_do <= '0;
        end else if (w_rd_act[gi]) begin
          if (!w_in_range) begin
            r_do <= INIT_VAL;
          end else if (w_hit) begin
            r_do <= di;
          end else begin
            r_do <= r_mem[w_rd_adr[gi]];
          end
        end
      end

      assign w_do[gi] = r_do;
    end
  endgenerate

  assign do0       = w_do[0];
  assign do1       = w_do[1];
  assign init_busy = (r_state != ST_READY);
  assign init_done = r_init_done;

endmodule

// File: doc/tri_array_2r1w_init.md
Name: tri_array_2r1w_init

Overview:
Parametrised successor to the fixed 64x72 single-read/single-write array wrapper. It supplies a DEPTH x WIDTH register-file array with:
- one write port and two independent read ports;
- registered reads with 1-cycle latency;
- selectable write-to-read bypass;
- a hardware clear sequencer that initialises every entry after reset.

It is used by GPR/FPR-style register files and queue payload arrays that need a second read port and guaranteed initial contents without ABIST.

Parameters:
DEPTH, 64, number of entries (2..2^ADDR_W)
ADDR_W, 6, address width
WIDTH, 72, data width in bits
BYPASS, 1, 1 = same-cycle write to the same address is forwarded to the read; 0 = read returns old data
INIT_VAL, 0, value written to every entry by the clear sequencer (WIDTH bits)

Ports:
clk  in  1  array clock, all state on rising edge
sreset  in  1  synchronous active-high reset
wr_act  in  1  write enable
wr_adr  in  ADDR_W  write address
di  in  WIDTH  write data
rd0_act  in  1  read port 0 enable
rd0_adr  in  ADDR_W  read port 0 address
do0  out  WIDTH  read port 0 data, registered
rd1_act  in  1  read port 1 enable
rd1_adr  in  ADDR_W  read port 1 address
do1  out  WIDTH  read port 1 data, registered
init_busy  out  1  clear sequence in progress; all accesses ignored
init_done  out  1  pulses high for 1 cycle when clear completes

Behaviour:
- One clock, clk. sreset is synchronous and active-high.
- FSM states: RST, CLEAR, READY.
- sreset=1 at an edge: state goes to RST; clr_cnt=0; do0=do1=0; init_busy=1; init_done=0. Array contents are not reset directly.
- RST -> CLEAR on the first edge with sreset=0.
- CLEAR, one entry per cycle:
  - writes INIT_VAL to entry clr_cnt, then clr_cnt+1;
  - at clr_cnt==DEPTH-1 the write still occurs, then the FSM goes to READY;
  - this takes exactly DEPTH cycles in CLEAR;
  - init_busy=1 throughout RST and CLEAR;
  - wr_act, rd0_act and rd1_act are ignored; do0/do1 hold 0.
- READY:
  - init_busy=0;
  - init_done=1 on the first READY cycle only;
  - the FSM stays in READY until sreset.
- sreset asserted mid-CLEAR: the sequence restarts from entry 0 after reset deasserts; any partially cleared state is irrelevant.
- Write (READY): wr_act=1 stores di at wr_adr on the edge. wr_adr >= DEPTH: the write is dropped.
- Read (READY): rdN_act=1 at edge k puts the entry at rdN_adr on doN after edge k (1-cycle latency).
  - rdN_act=0: doN holds its previous value.
  - rdN_adr >= DEPTH: doN = INIT_VAL.
- Both read ports are fully independent. Same address on both ports is legal and returns identical data.
- Collision (wr_act & rdN_act & wr_adr==rdN_adr, address in range, same edge):
  - BYPASS=1: doN = di;
  - BYPASS=0: doN = the value stored before the write.
  - In both cases the array holds di afterwards.
- Read the cycle after a write to the same address: always returns the new data.
- Width: data passes through unmodified. No parity or ECC. No partial-write masks.
- Implementation: behavioural memory plus output registers. Two read ports may be realised as duplicated storage. The clock must not be gated.

Test Plan:
- Reset then clear, DEPTH=64, INIT_VAL=72'h0: hold sreset 3 cycles, release -> init_busy=1 for exactly 65 cycles after release (RST + 64 CLEAR), init_done pulses 1 cycle. Reading addr 0 and addr 63 on both ports then returns 0.
- Write/read: write 72'hAB_CDEF0123_456789AB to addr 5. Next cycle read addr 5 on rd0 and addr 6 on rd1 -> one cycle later do0=72'hAB_CDEF0123_456789AB, do1=INIT_VAL. Drop rd0_act and rd1_act -> do0 and do1 hold.
- Collision: addr 9 holds 72'h11; same cycle write 72'h22 to addr 9 with rd0_adr=9 -> do0=72'h22 when BYPASS=1, 72'h11 when BYPASS=0. A following read of addr 9 gives 72'h22 in both builds.
- Accesses during clear: assert wr_act to addr 3 with 72'hFF and rd0_act during CLEAR -> ignored. After init_done, addr 3 reads INIT_VAL and do0 stayed 0 throughout CLEAR.
- Reset mid-clear: assert sreset at clr_cnt=30 for 1 cycle -> init_busy stays 1, and READY is reached exactly 65 cycles after release. Entries 0..63 all read INIT_VAL.
- Out of range, DEPTH=48, ADDR_W=6: write 72'h55 to addr 50 -> no entry changes. Reading addr 50 gives INIT_VAL. Reading addr 47 (last valid entry) after writing 72'h77 to it gives 72'h77.
